// File: rtl/rmt_pkg.sv
// Shared definitions for the deparser-side ingress stages: the FSM state
// encoding and the width of one packet-FIFO entry.
package rmt_pkg;

    // Common state encoding used by every deparser stage FSM.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    // One FIFO entry is {tdata, tuser, tkeep, tlast}.
    function automatic int fifo_entry_width(input int dw, input int uw);
        return dw + uw + dw / 8 + 1;
    endfunction

    localparam int C_DEF_DATA_WIDTH  = 512;
    localparam int C_DEF_TUSER_WIDTH = 128;
    localparam int C_FIFO_ENTRY_W    = fifo_entry_width(C_DEF_DATA_WIDTH, C_DEF_TUSER_WIDTH);

endpackage

// File: rtl/pkt_admit_ctrl_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Count increment events, stopping at the maximum value.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pkt_admit_ctrl.sv
// Ingress admission stage in front of the deparser packet FIFO.
// Decides admit/drop per packet at its first beat from FIFO occupancy,
// writes admitted packets (truncating over-long ones), sinks dropped ones,
// and keeps saturating packet/drop/truncate statistics.
//
// Handshake: an input beat transfers on a rising edge where
// s_axis_tvalid and s_axis_tready are both 1; tready never depends on
// tvalid. The FIFO side has no back-pressure input: pkt_fifo_wr_en is a
// write strobe and pkt_fifo_nearly_full leaves room for one in-flight write.
module pkt_admit_ctrl
    import rmt_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 512,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_MAX_SEGS         = 32,
    parameter int C_CNT_WIDTH        = 32
) (
    input  logic                                  axis_clk,
    input  logic                                  reset,
    input  logic [C_AXIS_DATA_WIDTH-1:0]          s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]        s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]         s_axis_tuser,
    input  logic                                  s_axis_tlast,
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    output logic [fifo_entry_width(C_AXIS_DATA_WIDTH, C_AXIS_TUSER_WIDTH)-1:0] pkt_fifo_din,
    output logic                                  pkt_fifo_wr_en,
    input  logic                                  pkt_fifo_nearly_full,
    output logic                                  admit_pulse,
    output logic                                  drop_pulse,
    output logic [C_CNT_WIDTH-1:0]                pkt_cnt,
    output logic [C_CNT_WIDTH-1:0]                drop_cnt,
    output logic [C_CNT_WIDTH-1:0]                trunc_cnt,
    output logic [1:0]                            o_dbg_state
);

    localparam int EW = fifo_entry_width(C_AXIS_DATA_WIDTH, C_AXIS_TUSER_WIDTH);
    localparam int BW = $clog2(C_MAX_SEGS + 1);

    state_t          r_state;
    state_t          w_next_state;
    logic [BW-1:0]   r_beat_cnt;
    logic [BW-1:0]   w_beat_idx;

    logic            w_tready;
    logic            w_fire;
    logic            w_write;
    logic            w_trunc;
    logic            w_admit;
    logic            w_drop;

    logic            r_wr_en;
    logic [EW-1:0]   r_din;
    logic            r_admit_pulse;
    logic            r_drop_pulse;
    logic            r_trunc_pulse;

    // State register; reset abandons any packet in progress.
    always_ff @(posedge axis_clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: decide at SOP, leave a packet on tlast, truncate into DROP.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_fire) begin
                    if (s_axis_tlast)              w_next_state = IDLE;
                    else if (pkt_fifo_nearly_full) w_next_state = DROP;
                    else if (w_trunc)              w_next_state = DROP;
                    else                           w_next_state = PASS;
                end
            end
            PASS: begin
                if (w_fire) begin
                    if (s_axis_tlast)              w_next_state = IDLE;
                    else if (w_trunc)              w_next_state = DROP;
                end
            end
            DROP: begin
                if (w_fire && s_axis_tlast)        w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs of the FSM: ready, write/decision strobes and truncation.
    always_comb begin
        w_tready = 1'b0;
        w_fire   = 1'b0;
        w_write  = 1'b0;
        w_admit  = 1'b0;
        w_drop   = 1'b0;
        w_trunc  = 1'b0;
        case (r_state)
            IDLE:    w_tready = 1'b1;
            PASS:    w_tready = ~pkt_fifo_nearly_full;
            DROP:    w_tready = 1'b1;
            default: w_tready = 1'b0;
        endcase
        if (reset) begin
            w_tready = 1'b0;
        end
        w_fire  = s_axis_tvalid & w_tready;
        w_admit = w_fire & (r_state == IDLE) & ~pkt_fifo_nearly_full;
        w_drop  = w_fire & (r_state == IDLE) &  pkt_fifo_nearly_full;
        w_write = w_admit | (w_fire & (r_state == PASS));
        w_trunc = w_write & ~s_axis_tlast & (w_beat_idx == BW'(C_MAX_SEGS - 1));
    end

    // Index of the beat currently on the bus within its packet.
    assign w_beat_idx = (r_state == IDLE) ? '0 : r_beat_cnt;

    // Beat counter: restarts at SOP, advances in PASS, frozen in DROP.
    always_ff @(posedge axis_clk) begin
        if (reset) begin
            r_beat_cnt <= '0;
        end else if (w_fire) begin
            if (r_state == IDLE) begin
                r_beat_cnt <= BW'(1);
            end else if ((r_state == PASS) && !w_trunc) begin
                r_beat_cnt <= r_beat_cnt + BW'(1);
            end
        end
    end

    // Registered write path and decision pulses, one cycle after acceptance.
    always_ff @(posedge axis_clk) begin
        if (reset) begin
            r_wr_en       <= 1'b0;
            r_din         <= '0;
            r_admit_pulse <= 1'b0;
            r_drop_pulse  <= 1'b0;
            r_trunc_pulse <= 1'b0;
        end else begin
            r_wr_en       <= w_write;
            r_admit_pulse <= w_admit;
            r_drop_pulse  <= w_drop;
            r_trunc_pulse <= w_trunc;
            if (w_write) begin
                r_din <= {s_axis_tdata, s_axis_tuser, s_axis_tkeep, s_axis_tlast | w_trunc};
            end
        end
    end

    sat_counter #(.WIDTH(C_CNT_WIDTH)) u_pkt_cnt (
        .i_clk   (axis_clk),
        .i_reset (reset),
        .i_inc   (r_admit_pulse),
        .o_count (pkt_cnt)
    );

    sat_counter #(.WIDTH(C_CNT_WIDTH)) u_drop_cnt (
        .i_clk   (axis_clk),
        .i_reset (reset),
        .i_inc   (r_drop_pulse),
        .o_count (drop_cnt)
    );

    sat_counter #(.WIDTH(C_CNT_WIDTH)) u_trunc_cnt (
        .i_clk   (axis_clk),
        .i_reset (reset),
        .i_inc   (r_trunc_pulse),
        .o_count (trunc_cnt)
    );

    assign s_axis_tready  = w_tready;
    assign pkt_fifo_wr_en = r_wr_en;
    assign pkt_fifo_din   = r_din;
    assign admit_pulse    = r_admit_pulse;
    assign drop_pulse     = r_drop_pulse;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_pkt_admit_ctrl.sv
// Directed bench for pkt_admit_ctrl with a write scoreboard.
module tb_pkt_admit_ctrl;

    localparam int DW  = 32;
    localparam int UW  = 8;
    localparam int KW  = DW / 8;
    localparam int MS  = 4;
    localparam int CW  = 4;
    localparam int EW  = DW + UW + KW + 1;
    localparam int CMX = (1 << CW) - 1;

    logic          axis_clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic [UW-1:0] s_axis_tuser = '0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [EW-1:0] pkt_fifo_din;
    logic          pkt_fifo_wr_en;
    logic          pkt_fifo_nearly_full = 1'b0;
    logic          admit_pulse;
    logic          drop_pulse;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] trunc_cnt;
    logic [1:0]    o_dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [EW-1:0] exp_q[$];

    bit mon_en      = 1'b0;
    bit m_exp_wr    = 1'b0;
    bit m_exp_admit = 1'b0;
    bit m_exp_drop  = 1'b0;
    bit m_in_pkt    = 1'b0;
    bit m_pass      = 1'b0;
    int m_idx       = 0;
    int exp_pkt     = 0;
    int exp_drop    = 0;
    int exp_trunc   = 0;

    pkt_admit_ctrl #(
        .C_AXIS_DATA_WIDTH  (DW),
        .C_AXIS_TUSER_WIDTH (UW),
        .C_MAX_SEGS         (MS),
        .C_CNT_WIDTH        (CW)
    ) dut (
        .axis_clk             (axis_clk),
        .reset                (reset),
        .s_axis_tdata         (s_axis_tdata),
        .s_axis_tkeep         (s_axis_tkeep),
        .s_axis_tuser         (s_axis_tuser),
        .s_axis_tlast         (s_axis_tlast),
        .s_axis_tvalid        (s_axis_tvalid),
        .s_axis_tready        (s_axis_tready),
        .pkt_fifo_din         (pkt_fifo_din),
        .pkt_fifo_wr_en       (pkt_fifo_wr_en),
        .pkt_fifo_nearly_full (pkt_fifo_nearly_full),
        .admit_pulse          (admit_pulse),
        .drop_pulse           (drop_pulse),
        .pkt_cnt              (pkt_cnt),
        .drop_cnt             (drop_cnt),
        .trunc_cnt            (trunc_cnt),
        .o_dbg_state          (o_dbg_state)
    );

    // Clock
    always #5 axis_clk = ~axis_clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CMX) ? CMX : v + 1;
    endfunction

    // Scoreboard side: every falling edge compares strobes and popped entries.
    always @(negedge axis_clk) begin
        if (mon_en) begin
            check("wr_en", 64'(pkt_fifo_wr_en), 64'(m_exp_wr));
            if (m_exp_wr && exp_q.size() > 0) begin
                check("din", 64'(pkt_fifo_din), 64'(exp_q.pop_front()));
            end
            check("admit_pulse", 64'(admit_pulse), 64'(m_exp_admit));
            check("drop_pulse", 64'(drop_pulse), 64'(m_exp_drop));
            m_exp_wr    = 1'b0;
            m_exp_admit = 1'b0;
            m_exp_drop  = 1'b0;
        end
    end

    task automatic model_reset();
        m_in_pkt  = 1'b0;
        m_pass    = 1'b0;
        m_idx     = 0;
        exp_pkt   = 0;
        exp_drop  = 0;
        exp_trunc = 0;
    endtask

    task automatic do_reset();
        reset                = 1'b1;
        s_axis_tvalid        = 1'b0;
        pkt_fifo_nearly_full = 1'b0;
        @(negedge axis_clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        repeat (n) @(negedge axis_clk);
    endtask

    // Drive one beat from a falling edge; predicts ready, write and decision.
    task automatic send_beat(input bit last, input bit nf, input int stall);
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        logic [KW-1:0] k;
        bit sop;
        bit exp_rdy;
        bit wr;
        bit trunc;
        int w;
        d = $urandom;
        u = UW'($urandom_range(0, 255));
        k = KW'($urandom_range(1, 15));
        sop = !m_in_pkt;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tkeep  = k;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        if (stall > 0) begin
            pkt_fifo_nearly_full = 1'b1;
            for (int i = 0; i < stall; i++) begin
                #1;
                check("tready_stall", 64'(s_axis_tready), 64'((m_in_pkt && m_pass) ? 1'b0 : 1'b1));
                @(negedge axis_clk);
            end
        end
        pkt_fifo_nearly_full = nf;
        #1;
        exp_rdy = (m_in_pkt && m_pass) ? !nf : 1'b1;
        check("tready", 64'(s_axis_tready), 64'(exp_rdy));
        w = 0;
        while (!s_axis_tready && w < 20) begin
            @(negedge axis_clk);
            #1;
            w++;
        end
        if (!s_axis_tready) begin
            check("tready_timeout", 64'(s_axis_tready), 64'(1));
            s_axis_tvalid = 1'b0;
            return;
        end
        if (sop) begin
            m_pass = !nf;
            m_idx  = 0;
        end
        wr    = m_pass;
        trunc = m_pass && !last && (m_idx == MS - 1);
        @(posedge axis_clk);
        if (sop) begin
            if (!nf) begin
                m_exp_admit = 1'b1;
                exp_pkt     = sat_inc(exp_pkt);
            end else begin
                m_exp_drop = 1'b1;
                exp_drop   = sat_inc(exp_drop);
            end
        end
        if (wr) begin
            exp_q.push_back({d, u, k, last | trunc});
            m_exp_wr = 1'b1;
        end
        if (trunc) begin
            exp_trunc = sat_inc(exp_trunc);
            m_pass    = 1'b0;
        end
        m_idx++;
        m_in_pkt = !last;
        @(negedge axis_clk);
    endtask

    task automatic send_pkt(input int n, input bit nf, input int stall_beat, input int stall_cyc);
        for (int i = 0; i < n; i++) begin
            send_beat(i == n - 1, nf, (i == stall_beat) ? stall_cyc : 0);
        end
    endtask

    task automatic check_counters(input string tag);
        idle(3);
        check({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(exp_pkt));
        check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
        check({tag, "_trunc_cnt"}, 64'(trunc_cnt), 64'(exp_trunc));
        check({tag, "_state"}, 64'(o_dbg_state), 64'(0));
        check({tag, "_q_empty"}, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        // Power-on reset
        reset = 1'b1;
        repeat (3) @(negedge axis_clk);
        reset = 1'b0;
        model_reset();
        mon_en = 1'b1;
        #1;
        check("rst_wr_en", 64'(pkt_fifo_wr_en), 64'(0));
        check("rst_din", 64'(pkt_fifo_din), 64'(0));
        check("rst_state", 64'(o_dbg_state), 64'(0));
        check("rst_tready", 64'(s_axis_tready), 64'(1));
        check("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
        check("rst_drop_cnt", 64'(drop_cnt), 64'(0));
        check("rst_trunc_cnt", 64'(trunc_cnt), 64'(0));
        @(negedge axis_clk);

        // 1: 3-beat admitted packet
        send_pkt(3, 1'b0, -1, 0);
        check_counters("t1");

        // 2: dropped 4-beat packet (nearly_full at SOP)
        do_reset();
        send_pkt(4, 1'b1, -1, 0);
        check_counters("t2");

        // 3: 5-beat packet stalled by nearly_full on beat 2
        do_reset();
        send_pkt(5, 1'b0, 2, 3);
        check_counters("t3");

        // 4: 7-beat packet truncated to MS beats, then a normal packet
        do_reset();
        send_pkt(7, 1'b0, -1, 0);
        send_pkt(2, 1'b0, -1, 0);
        check_counters("t4");

        // 5: ten back-to-back single-beat packets
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send_beat(1'b1, 1'b0, 0);
        end
        check_counters("t5");

        // 6: reset on beat 2, next beat is a SOP, then drop saturation
        do_reset();
        send_beat(1'b0, 1'b0, 0);
        send_beat(1'b0, 1'b0, 0);
        do_reset();
        check("t6_wr_en", 64'(pkt_fifo_wr_en), 64'(0));
        check("t6_admit", 64'(admit_pulse), 64'(0));
        check("t6_drop", 64'(drop_pulse), 64'(0));
        check("t6_state", 64'(o_dbg_state), 64'(0));
        check("t6_pkt_cnt", 64'(pkt_cnt), 64'(0));
        send_beat(1'b0, 1'b1, 0);
        send_beat(1'b1, 1'b0, 0);
        for (int i = 0; i < 19; i++) begin
            send_beat(1'b1, 1'b1, 0);
        end
        check_counters("t6");
        check("t6_drop_sat", 64'(drop_cnt), 64'(15));

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
